// File: rtl/elevator_if.sv
// Signal bundle between the elevator controller (slave) and the car/hall side (master).
interface elevator_if #(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
);
    logic [NUM_FLOORS-1:0] floor_sensor;
    logic [NUM_FLOORS-1:0] car_req;
    logic [NUM_FLOORS-1:0] hall_up;
    logic [NUM_FLOORS-1:0] hall_down;
    logic                  door_hold;
    logic [1:0]            ac;
    logic [FLOOR_W-1:0]    display;
    logic                  door_open;
    logic                  dir_up;
    logic [NUM_FLOORS-1:0] pend_car;
    logic [NUM_FLOORS-1:0] pend_up;
    logic [NUM_FLOORS-1:0] pend_down;

    modport master (
        output floor_sensor, car_req, hall_up, hall_down, door_hold,
        input  ac, display, door_open, dir_up, pend_car, pend_up, pend_down
    );
    modport slave (
        input  floor_sensor, car_req, hall_up, hall_down, door_hold,
        output ac, display, door_open, dir_up, pend_car, pend_up, pend_down
    );
endinterface

// File: rtl/elevator_ctrl_n.sv
// Collective (SCAN) elevator controller: edge-captured requests, direction kept
// while requests remain ahead, programmable door dwell with hold/reopen.
module elevator_ctrl_n #(
    parameter int NUM_FLOORS  = 4,
    parameter int DOOR_CYCLES = 8,
    localparam int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic      clk,
    input  logic      rst_n,
    elevator_if.slave bus
);
    localparam int                    TMR_W = $clog2(DOOR_CYCLES + 1);
    localparam logic [TMR_W-1:0]      DWELL = TMR_W'(DOOR_CYCLES);
    localparam logic [NUM_FLOORS-1:0] ONE   = NUM_FLOORS'(1'b1);
    localparam logic [NUM_FLOORS-1:0] UP_OK = ~(ONE << (NUM_FLOORS - 1));
    localparam logic [NUM_FLOORS-1:0] DN_OK = ~ONE;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR_OPEN = 2'd3
    } state_t;

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) r = r | (v[i] & (i > int'(f)));
        return r;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) r = r | (v[i] & (i < int'(f)));
        return r;
    endfunction

    function automatic logic [FLOOR_W-1:0] onehot_idx(input logic [NUM_FLOORS-1:0] v);
        logic [FLOOR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_FLOORS; i++) idx = v[i] ? FLOOR_W'(i) : idx;
        return idx;
    endfunction

    state_t                state_r, state_nx_s, res_state_s;
    logic [FLOOR_W-1:0]    display_r, display_nx_s, sens_idx_s;
    logic                  dir_up_r, dir_nx_s, res_dir_s;
    logic [TMR_W-1:0]      timer_r, timer_nx_s;
    logic [1:0]            ac_r, ac_s;
    logic                  door_open_r, door_open_s;
    logic [NUM_FLOORS-1:0] car_prev_r, up_prev_r, dn_prev_r;
    logic [NUM_FLOORS-1:0] pend_car_r, pend_up_r, pend_dn_r;
    logic [NUM_FLOORS-1:0] car_edge_s, up_edge_s, dn_edge_s, pend_any_s;
    logic [NUM_FLOORS-1:0] disp_bit_s, sens_bit_s, clr_car_s, clr_up_s, clr_dn_s;
    logic                  sens_ok_s, here_s, ahead_up_s, ahead_dn_s;
    logic                  k_stop_up_s, k_stop_dn_s, k_ahead_up_s, k_ahead_dn_s;
    logic                  arr_up_s, arr_dn_s;

    // Button edges, request geometry and the resume decision shared by IDLE and door close
    always_comb begin
        car_edge_s   = bus.car_req & ~car_prev_r;
        up_edge_s    = bus.hall_up & ~up_prev_r & UP_OK;
        dn_edge_s    = bus.hall_down & ~dn_prev_r & DN_OK;
        pend_any_s   = pend_car_r | pend_up_r | pend_dn_r;
        disp_bit_s   = ONE << display_r;
        sens_idx_s   = onehot_idx(bus.floor_sensor);
        sens_bit_s   = ONE << sens_idx_s;
        sens_ok_s    = $onehot(bus.floor_sensor);
        here_s       = |(pend_any_s & disp_bit_s);
        ahead_up_s   = any_above(pend_any_s, display_r);
        ahead_dn_s   = any_below(pend_any_s, display_r);
        k_ahead_up_s = any_above(pend_any_s, sens_idx_s);
        k_ahead_dn_s = any_below(pend_any_s, sens_idx_s);
        k_stop_up_s  = (|((pend_car_r | pend_up_r) & sens_bit_s)) | ~k_ahead_up_s;
        k_stop_dn_s  = (|((pend_car_r | pend_dn_r) & sens_bit_s)) | ~k_ahead_dn_s;
        arr_up_s     = sens_ok_s && (int'(sens_idx_s) == int'(display_r) + 1);
        arr_dn_s     = sens_ok_s && (int'(sens_idx_s) + 1 == int'(display_r));
        if (dir_up_r && ahead_up_s) begin
            res_state_s = ST_MOVE_UP;   res_dir_s = 1'b1;
        end else if (!dir_up_r && ahead_dn_s) begin
            res_state_s = ST_MOVE_DOWN; res_dir_s = 1'b0;
        end else if (ahead_dn_s) begin
            res_state_s = ST_MOVE_DOWN; res_dir_s = 1'b0;
        end else if (ahead_up_s) begin
            res_state_s = ST_MOVE_UP;   res_dir_s = 1'b1;
        end else begin
            res_state_s = ST_IDLE;      res_dir_s = dir_up_r;
        end
    end

    // Next-state, floor, direction, timer and request-clear decisions
    always_comb begin
        state_nx_s   = state_r;
        display_nx_s = display_r;
        dir_nx_s     = dir_up_r;
        timer_nx_s   = timer_r;
        clr_car_s    = '0;
        clr_up_s     = '0;
        clr_dn_s     = '0;
        case (state_r)
            ST_IDLE: begin
                if (here_s) begin
                    state_nx_s = ST_DOOR_OPEN;
                    timer_nx_s = DWELL;
                    clr_car_s  = disp_bit_s;
                    clr_up_s   = disp_bit_s;
                    clr_dn_s   = disp_bit_s;
                end else begin
                    state_nx_s = res_state_s;
                    dir_nx_s   = res_dir_s;
                end
            end
            ST_MOVE_UP: begin
                if (arr_up_s) begin
                    display_nx_s = sens_idx_s;
                    if (k_stop_up_s) begin
                        state_nx_s = ST_DOOR_OPEN;
                        timer_nx_s = DWELL;
                        clr_car_s  = sens_bit_s;
                        clr_up_s   = sens_bit_s;
                        dir_nx_s   = k_ahead_up_s;
                        clr_dn_s   = k_ahead_up_s ? '0 : sens_bit_s;
                    end else begin
                        state_nx_s = ST_MOVE_UP;
                    end
                end else begin
                    state_nx_s = ST_MOVE_UP;
                end
            end
            ST_MOVE_DOWN: begin
                if (arr_dn_s) begin
                    display_nx_s = sens_idx_s;
                    if (k_stop_dn_s) begin
                        state_nx_s = ST_DOOR_OPEN;
                        timer_nx_s = DWELL;
                        clr_car_s  = sens_bit_s;
                        clr_dn_s   = sens_bit_s;
                        dir_nx_s   = ~k_ahead_dn_s;
                        clr_up_s   = k_ahead_dn_s ? '0 : sens_bit_s;
                    end else begin
                        state_nx_s = ST_MOVE_DOWN;
                    end
                end else begin
                    state_nx_s = ST_MOVE_DOWN;
                end
            end
            ST_DOOR_OPEN: begin
                // A fresh press at this floor reopens the dwell and is absorbed, never latched
                clr_car_s = car_edge_s & disp_bit_s;
                clr_up_s  = up_edge_s & disp_bit_s;
                clr_dn_s  = dn_edge_s & disp_bit_s;
                if (bus.door_hold || (|(clr_car_s | clr_up_s | clr_dn_s))) begin
                    timer_nx_s = DWELL;
                end else if (timer_r <= TMR_W'(1'b1)) begin
                    timer_nx_s = '0;
                    state_nx_s = res_state_s;
                    dir_nx_s   = res_dir_s;
                end else begin
                    timer_nx_s = timer_r - TMR_W'(1'b1);
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Motor and door commands follow the upcoming state
    always_comb begin
        case (state_nx_s)
            ST_MOVE_UP:   begin ac_s = 2'b10; door_open_s = 1'b0; end
            ST_MOVE_DOWN: begin ac_s = 2'b01; door_open_s = 1'b0; end
            ST_DOOR_OPEN: begin ac_s = 2'b00; door_open_s = 1'b1; end
            default:      begin ac_s = 2'b00; door_open_s = 1'b0; end
        endcase
    end

    // State and command output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ac_r        <= 2'b00;
            door_open_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            ac_r        <= ac_s;
            door_open_r <= door_open_s;
        end
    end

    // Floor, direction, timer, button history and pending-request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_r  <= '0;
            dir_up_r   <= 1'b1;
            timer_r    <= '0;
            car_prev_r <= '0;
            up_prev_r  <= '0;
            dn_prev_r  <= '0;
            pend_car_r <= '0;
            pend_up_r  <= '0;
            pend_dn_r  <= '0;
        end else begin
            display_r  <= display_nx_s;
            dir_up_r   <= dir_nx_s;
            timer_r    <= timer_nx_s;
            car_prev_r <= bus.car_req;
            up_prev_r  <= bus.hall_up;
            dn_prev_r  <= bus.hall_down;
            pend_car_r <= (pend_car_r | car_edge_s) & ~clr_car_s;
            pend_up_r  <= (pend_up_r | up_edge_s) & ~clr_up_s;
            pend_dn_r  <= (pend_dn_r | dn_edge_s) & ~clr_dn_s;
        end
    end

    assign bus.ac        = ac_r;
    assign bus.display   = display_r;
    assign bus.door_open = door_open_r;
    assign bus.dir_up    = dir_up_r;
    assign bus.pend_car  = pend_car_r;
    assign bus.pend_up   = pend_up_r;
    assign bus.pend_down = pend_dn_r;
endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Scoreboard bench for elevator_ctrl_n (4 floors, 3-cycle dwell): expected outputs
// are queued with the stimulus and compared on the falling edge after they are due.
module tb_elevator_ctrl_n;
    logic clk;
    logic rst_n;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;

    typedef struct {
        string      tag;
        int         due;
        logic [1:0] ac;
        logic [1:0] disp;
        logic       door;
        logic       dir;
        logic [3:0] pc;
        logic [3:0] pu;
        logic [3:0] pd;
    } exp_t;

    exp_t sb[$];

    elevator_if #(.NUM_FLOORS(4)) bus_if ();

    elevator_ctrl_n #(.NUM_FLOORS(4), .DOOR_CYCLES(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare every expectation whose cycle has arrived
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk_eq({e.tag, ".ac"},   32'(bus_if.ac),        32'(e.ac));
            chk_eq({e.tag, ".disp"}, 32'(bus_if.display),   32'(e.disp));
            chk_eq({e.tag, ".door"}, 32'(bus_if.door_open), 32'(e.door));
            chk_eq({e.tag, ".dir"},  32'(bus_if.dir_up),    32'(e.dir));
            chk_eq({e.tag, ".pc"},   32'(bus_if.pend_car),  32'(e.pc));
            chk_eq({e.tag, ".pu"},   32'(bus_if.pend_up),   32'(e.pu));
            chk_eq({e.tag, ".pd"},   32'(bus_if.pend_down), 32'(e.pd));
        end
    end

    // Queue the outputs expected after the next rising edge, then advance one cycle
    task automatic st(input string tag, input logic [1:0] ac, input logic [1:0] disp,
                      input logic door, input logic dir,
                      input logic [3:0] pc, input logic [3:0] pu, input logic [3:0] pd);
        exp_t e;
        e = '{tag, cyc + 1, ac, disp, door, dir, pc, pu, pd};
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk_eq({tag, ".ac"},   32'(bus_if.ac),        32'(2'b00));
        chk_eq({tag, ".disp"}, 32'(bus_if.display),   32'(2'd0));
        chk_eq({tag, ".door"}, 32'(bus_if.door_open), 32'(1'b0));
        chk_eq({tag, ".dir"},  32'(bus_if.dir_up),    32'(1'b1));
        chk_eq({tag, ".pc"},   32'(bus_if.pend_car),  32'(4'b0000));
        chk_eq({tag, ".pu"},   32'(bus_if.pend_up),   32'(4'b0000));
        chk_eq({tag, ".pd"},   32'(bus_if.pend_down), 32'(4'b0000));
    endtask

    initial begin
        rst_n               = 1'b0;
        bus_if.floor_sensor = 4'b0001;
        bus_if.car_req      = 4'b0000;
        bus_if.hall_up      = 4'b0000;
        bus_if.hall_down    = 4'b0000;
        bus_if.door_hold    = 1'b0;
        #12;
        chk_reset("rst0");
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ride from floor 0 to a car call at floor 2, then a 3-cycle dwell
        bus_if.car_req = 4'b0100;
        st("t1.latch", 2'b00, 2'd0, 1'b0, 1'b1, 4'b0100, 4'b0000, 4'b0000);
        bus_if.car_req = 4'b0000;
        st("t1.start", 2'b10, 2'd0, 1'b0, 1'b1, 4'b0100, 4'b0000, 4'b0000);
        bus_if.floor_sensor = 4'b0000;
        st("t1.gap",   2'b10, 2'd0, 1'b0, 1'b1, 4'b0100, 4'b0000, 4'b0000);
        bus_if.floor_sensor = 4'b0010;
        st("t1.f1",    2'b10, 2'd1, 1'b0, 1'b1, 4'b0100, 4'b0000, 4'b0000);
        bus_if.floor_sensor = 4'b0100;
        st("t1.stop",  2'b00, 2'd2, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        st("t1.dw1",   2'b00, 2'd2, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        st("t1.dw2",   2'b00, 2'd2, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        st("t1.close", 2'b00, 2'd2, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        st("t1.idle",  2'b00, 2'd2, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000);

        // Door hold and a re-press at the open floor both reload the dwell
        bus_if.car_req = 4'b0100;
        st("t3.latch", 2'b00, 2'd2, 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0000);
        bus_if.car_req = 4'b0000;
        st("t3.open",  2'b00, 2'd2, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        bus_if.door_hold = 1'b1;
        for (int i = 0; i < 5; i++)
            st("t3.hold", 2'b00, 2'd2, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        bus_if.door_hold = 1'b0;
        bus_if.car_req   = 4'b0100;
        st("t3.repress", 2'b00, 2'd2, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        st("t3.dw1",     2'b00, 2'd2, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        st("t3.dw2",     2'b00, 2'd2, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        st("t3.close",   2'b00, 2'd2, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        bus_if.car_req = 4'b0000;
        st("t3.idle",    2'b00, 2'd2, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000);

        // Return to floor 0; direction flips to up at the bottom
        bus_if.car_req = 4'b0001;
        st("h.latch", 2'b00, 2'd2, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000);
        bus_if.car_req = 4'b0000;
        st("h.start", 2'b01, 2'd2, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000);
        bus_if.floor_sensor = 4'b0010;
        st("h.f1",    2'b01, 2'd1, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000);
        bus_if.floor_sensor = 4'b0001;
        st("h.stop",  2'b00, 2'd0, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        st("h.dw1",   2'b00, 2'd0, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        st("h.dw2",   2'b00, 2'd0, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        st("h.close", 2'b00, 2'd0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);

        // Pass a down call at 1 going up, serve 3, come back for it
        bus_if.hall_down = 4'b0010;
        bus_if.car_req   = 4'b1000;
        st("t2.latch", 2'b00, 2'd0, 1'b0, 1'b1, 4'b1000, 4'b0000, 4'b0010);
        bus_if.hall_down = 4'b0000;
        bus_if.car_req   = 4'b0000;
        st("t2.start", 2'b10, 2'd0, 1'b0, 1'b1, 4'b1000, 4'b0000, 4'b0010);
        bus_if.floor_sensor = 4'b0010;
        st("t2.pass1", 2'b10, 2'd1, 1'b0, 1'b1, 4'b1000, 4'b0000, 4'b0010);
        bus_if.floor_sensor = 4'b0100;
        st("t2.f2",    2'b10, 2'd2, 1'b0, 1'b1, 4'b1000, 4'b0000, 4'b0010);
        bus_if.floor_sensor = 4'b1000;
        st("t2.stop3", 2'b00, 2'd3, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0010);
        st("t2.dw1",   2'b00, 2'd3, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0010);
        st("t2.dw2",   2'b00, 2'd3, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0010);
        st("t2.down",  2'b01, 2'd3, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0010);
        bus_if.floor_sensor = 4'b0100;
        st("t2.f2d",   2'b01, 2'd2, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0010);
        bus_if.floor_sensor = 4'b0010;
        st("t2.stop1", 2'b00, 2'd1, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        st("t2.dw3",   2'b00, 2'd1, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        st("t2.dw4",   2'b00, 2'd1, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        st("t2.idle",  2'b00, 2'd1, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);

        // Calls above and below at once from floor 1 heading up; multi-hot sensor ignored
        bus_if.car_req = 4'b1001;
        st("t4.latch", 2'b00, 2'd1, 1'b0, 1'b1, 4'b1001, 4'b0000, 4'b0000);
        bus_if.car_req = 4'b0000;
        st("t4.up",    2'b10, 2'd1, 1'b0, 1'b1, 4'b1001, 4'b0000, 4'b0000);
        bus_if.floor_sensor = 4'b0100;
        st("t4.f2",    2'b10, 2'd2, 1'b0, 1'b1, 4'b1001, 4'b0000, 4'b0000);
        bus_if.floor_sensor = 4'b1000;
        st("t4.stop3", 2'b00, 2'd3, 1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000);
        st("t4.dw1",   2'b00, 2'd3, 1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000);
        st("t4.dw2",   2'b00, 2'd3, 1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000);
        st("t4.down",  2'b01, 2'd3, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000);
        bus_if.floor_sensor = 4'b0110;
        st("t5.multi", 2'b01, 2'd3, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000);
        bus_if.floor_sensor = 4'b0100;
        st("t4.f2d",   2'b01, 2'd2, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000);
        bus_if.floor_sensor = 4'b0010;
        st("t4.f1d",   2'b01, 2'd1, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000);
        bus_if.floor_sensor = 4'b0001;
        st("t4.stop0", 2'b00, 2'd0, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        st("t4.dw3",   2'b00, 2'd0, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        st("t4.dw4",   2'b00, 2'd0, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        st("t4.idle",  2'b00, 2'd0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);

        // Ignored hall buttons never latch
        bus_if.hall_up   = 4'b1000;
        bus_if.hall_down = 4'b0001;
        st("t5.ign1", 2'b00, 2'd0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        bus_if.hall_up   = 4'b0000;
        bus_if.hall_down = 4'b0000;
        st("t5.ign2", 2'b00, 2'd0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);

        // Asynchronous reset while moving at floor 2
        bus_if.car_req = 4'b1000;
        st("t6.latch", 2'b00, 2'd0, 1'b0, 1'b1, 4'b1000, 4'b0000, 4'b0000);
        bus_if.car_req = 4'b0000;
        st("t6.start", 2'b10, 2'd0, 1'b0, 1'b1, 4'b1000, 4'b0000, 4'b0000);
        bus_if.floor_sensor = 4'b0010;
        st("t6.f1",    2'b10, 2'd1, 1'b0, 1'b1, 4'b1000, 4'b0000, 4'b0000);
        bus_if.floor_sensor = 4'b0100;
        st("t6.f2",    2'b10, 2'd2, 1'b0, 1'b1, 4'b1000, 4'b0000, 4'b0000);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset("t6.async");
        bus_if.floor_sensor = 4'b0001;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        st("t6.after", 2'b00, 2'd0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);

        repeat (3) @(negedge clk);
        chk_eq("drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
